// File: rtl/scoot_bot_seq.sv
// Scootbot decision loop: one registered DECIDE cycle, then a move held until move_ready (1 move / 2 cycles max).
// Define SCOOT_ESCAPE_EN to enable down-move stuck recovery; otherwise blocks only flip the crawl phase.
module scoot_bot_seq #(
  parameter int UP_RUN      = 1,
  parameter int LEFT_RUN    = 1,
  parameter int STUCK_LIMIT = 4,
  parameter int ESC_LEN     = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sense_up,
  input  logic             sense_left,
  input  logic             sense_down,
  input  logic             sense_right,
  input  logic             blocked,
  input  logic             move_ready,
  output logic             move_valid,
  output logic [3:0]       move,
  output logic [CNT_W-1:0] collected
);

`ifdef SCOOT_ESCAPE_EN
  localparam bit ESC_EN = 1'b1;
`else
  localparam bit ESC_EN = 1'b0;
`endif

  localparam int RUN_MAX = (UP_RUN > LEFT_RUN) ? UP_RUN : LEFT_RUN;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam int STK_W   = $clog2(STUCK_LIMIT + 1);
  localparam int ESC_W   = $clog2(ESC_LEN + 1);

  localparam logic [1:0] S_DECIDE = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_ESCAPE = 2'd2;

  localparam logic [3:0] M_UP    = 4'b0001;
  localparam logic [3:0] M_LEFT  = 4'b0010;
  localparam logic [3:0] M_DOWN  = 4'b0100;
  localparam logic [3:0] M_RIGHT = 4'b1000;

  localparam logic PH_UP   = 1'b0;
  localparam logic PH_LEFT = 1'b1;

  logic [1:0]       state;
  logic [3:0]       dir;
  logic             pat_mv;
  logic             hit;
  logic             phase;
  logic [RUN_W-1:0] run_cnt;
  logic [STK_W-1:0] stuck_cnt;
  logic             esc_pend;
  logic [ESC_W-1:0] esc_cnt;

  logic [3:0]       sel_dir;
  logic             sel_pat;
  logic             run_last;
  logic             esc_last;
  logic [STK_W-1:0] stuck_nxt;
  logic             issue_xfer;
  logic             esc_xfer;

  // Outputs decode straight from state so an async reset drops them at once.
  assign move_valid = (state == S_ISSUE) || (state == S_ESCAPE);
  assign move       = move_valid ? dir : 4'b0000;

  assign issue_xfer = (state == S_ISSUE) && move_ready;
  assign esc_xfer   = (state == S_ESCAPE) && move_ready;

  assign run_last = (phase == PH_UP) ? (run_cnt == RUN_W'(UP_RUN - 1))
                                     : (run_cnt == RUN_W'(LEFT_RUN - 1));
  assign esc_last = (esc_cnt == ESC_W'(ESC_LEN - 1));

  always_comb begin
    stuck_nxt = '0;
    if (blocked) begin
      stuck_nxt = (stuck_cnt == STK_W'(STUCK_LIMIT)) ? stuck_cnt : stuck_cnt + STK_W'(1);
    end
  end

  // Right beats up beats left; down is never sensor-chosen.
  always_comb begin
    sel_dir = M_UP;
    sel_pat = 1'b0;
    if (sense_right) begin
      sel_dir = M_RIGHT;
    end else if (sense_up) begin
      sel_dir = M_UP;
    end else if (sense_left) begin
      sel_dir = M_LEFT;
    end else begin
      sel_pat = 1'b1;
      sel_dir = (phase == PH_LEFT) ? M_LEFT : M_UP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_DECIDE;
      dir    <= 4'b0000;
      pat_mv <= 1'b0;
      hit    <= 1'b0;
    end else begin
      case (state)
        S_DECIDE: begin
          if (esc_pend) begin
            state  <= S_ESCAPE;
            dir    <= M_DOWN;
            pat_mv <= 1'b0;
            hit    <= 1'b0;
          end else begin
            state  <= S_ISSUE;
            dir    <= sel_dir;
            pat_mv <= sel_pat;
            hit    <= !sel_pat;
          end
        end
        S_ISSUE:  if (move_ready) state <= S_DECIDE;
        S_ESCAPE: if (move_ready) state <= S_DECIDE;
        default:  state <= S_DECIDE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase     <= PH_UP;
      run_cnt   <= '0;
      stuck_cnt <= '0;
      collected <= '0;
    end else if (issue_xfer) begin
      stuck_cnt <= stuck_nxt;
      if (blocked) begin
        phase   <= ~phase;
        run_cnt <= '0;
      end else begin
        if (hit && (collected != '1)) collected <= collected + CNT_W'(1);
        if (pat_mv) begin
          if (run_last) begin
            phase   <= ~phase;
            run_cnt <= '0;
          end else begin
            run_cnt <= run_cnt + RUN_W'(1);
          end
        end
      end
    end else if (esc_xfer && esc_last) begin
      stuck_cnt <= '0;
      phase     <= PH_UP;
      run_cnt   <= '0;
    end
  end

  // Escape is armed by the transfer that brings stuck_cnt to the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      esc_pend <= 1'b0;
      esc_cnt  <= '0;
    end else if (ESC_EN && issue_xfer && (stuck_nxt == STK_W'(STUCK_LIMIT))) begin
      esc_pend <= 1'b1;
      esc_cnt  <= '0;
    end else if (esc_xfer) begin
      esc_cnt <= esc_cnt + ESC_W'(1);
      if (esc_last) esc_pend <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = sense_down;

endmodule

// File: tb/tb_scoot_bot_seq.sv
// Directed + randomized bench for scoot_bot_seq against a transaction-level move model.
module tb_scoot_bot_seq;
  localparam int UP_RUN      = 2;
  localparam int LEFT_RUN    = 1;
  localparam int STUCK_LIMIT = 3;
  localparam int ESC_LEN     = 2;
  localparam int CNT_W       = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             sense_up = 1'b0, sense_left = 1'b0, sense_down = 1'b0, sense_right = 1'b0;
  logic             blocked = 1'b0;
  logic             move_ready = 1'b0;
  logic             move_valid;
  logic [3:0]       move;
  logic [CNT_W-1:0] collected;

  scoot_bot_seq #(
    .UP_RUN(UP_RUN), .LEFT_RUN(LEFT_RUN), .STUCK_LIMIT(STUCK_LIMIT),
    .ESC_LEN(ESC_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .sense_up(sense_up), .sense_left(sense_left), .sense_down(sense_down), .sense_right(sense_right),
    .blocked(blocked), .move_ready(move_ready),
    .move_valid(move_valid), .move(move), .collected(collected)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: crawl phase (0 = up, 1 = left), moves done in the phase, stuck count,
  // score and remaining escape moves.
  int m_phase, m_run, m_stuck, m_coll, m_esc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_stuck = 0; m_coll = 0; m_esc = 0;
  endtask

  // Sensor vector s: [0]=up [1]=left [2]=down [3]=right, same as move.
  function automatic logic [3:0] model_pick(input logic [3:0] s, output bit pat);
    pat = 1'b0;
    if (m_esc > 0) return 4'b0100;
    if (s[3]) return 4'b1000;
    if (s[0]) return 4'b0001;
    if (s[1]) return 4'b0010;
    pat = 1'b1;
    return (m_phase == 1) ? 4'b0010 : 4'b0001;
  endfunction

  task automatic model_xfer(input logic [3:0] chosen, input bit pat, input bit esc,
                            input logic blk, input logic [3:0] s);
    if (esc) begin
      m_esc--;
      if (m_esc == 0) begin
        m_stuck = 0; m_phase = 0; m_run = 0;
      end
      return;
    end
    if (blk) begin
      m_stuck = (m_stuck < STUCK_LIMIT) ? m_stuck + 1 : STUCK_LIMIT;
      m_phase = 1 - m_phase;
      m_run   = 0;
    end else begin
      m_stuck = 0;
      if (((chosen & s) != 4'b0000) && (m_coll < CNT_MAX)) m_coll++;
      if (pat) begin
        m_run++;
        if (m_run == ((m_phase == 1) ? LEFT_RUN : UP_RUN)) begin
          m_phase = 1 - m_phase;
          m_run   = 0;
        end
      end
    end
`ifdef SCOOT_ESCAPE_EN
    if (m_stuck == STUCK_LIMIT) m_esc = ESC_LEN;
`endif
  endtask

  // Entered mid-cycle while the DUT is in its DECIDE cycle; returns mid-cycle in the next one.
  task automatic do_move(input logic [3:0] s, input int stall, input logic blk, output logic [3:0] obs);
    logic [3:0] exp;
    bit pat, esc;
    esc = (m_esc > 0);
    exp = model_pick(s, pat);
    {sense_right, sense_down, sense_left, sense_up} = s;
    move_ready = 1'($urandom_range(0, 1));
    blocked    = 1'($urandom_range(0, 1));
    #1;
    chk("idle_valid", {31'd0, move_valid}, 32'd0);
    chk("idle_move", {28'd0, move}, 32'd0);
    @(posedge clk); #1;
    move_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      {sense_right, sense_down, sense_left, sense_up} = 4'($urandom);
      chk("stall_valid", {31'd0, move_valid}, 32'd1);
      chk("stall_move", {28'd0, move}, {28'd0, exp});
      @(posedge clk); #1;
    end
    move_ready = 1'b1;
    blocked    = blk;
    #1;
    chk("xfer_valid", {31'd0, move_valid}, 32'd1);
    chk("xfer_move", {28'd0, move}, {28'd0, exp});
    obs = move;
    @(posedge clk); #1;
    move_ready = 1'b0;
    blocked    = 1'b0;
    model_xfer(exp, pat, esc, blk, s);
    chk("collected", {{(32-CNT_W){1'b0}}, collected}, m_coll);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] obs;
    logic [3:0] crawl_tab [6];
    logic [CNT_W-1:0] sat_tab [5];
    crawl_tab = '{4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0010};
    sat_tab   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Reset state
    #1;
    chk("rst_valid", {31'd0, move_valid}, 32'd0);
    chk("rst_move", {28'd0, move}, 32'd0);
    chk("rst_collected", {{(32-CNT_W){1'b0}}, collected}, 32'd0);
    model_reset();
    release_reset();

    // Crawl pattern with no sensors and ready immediately
    for (int i = 0; i < 6; i++) begin
      do_move(4'b0000, 0, 1'b0, obs);
      chk("crawl_seq", {28'd0, obs}, {28'd0, crawl_tab[i]});
    end

    // Right beats up, item collected
    do_move(4'b1001, 0, 1'b0, obs);
    chk("prio_right", {28'd0, obs}, 32'h8);
    chk("prio_collect", {{(32-CNT_W){1'b0}}, collected}, 32'd1);

    // Long stall with sensors churning during ISSUE
    do_move(4'b0000, 5, 1'b0, obs);
    chk("stall_dir", {28'd0, obs}, 32'h1);

    // Three blocked transfers reach the stuck limit
    for (int i = 0; i < 3; i++) do_move(4'b0000, 0, 1'b1, obs);
`ifdef SCOOT_ESCAPE_EN
    for (int i = 0; i < 2; i++) begin
      do_move(4'b1111, 1, 1'b1, obs);
      chk("escape_down", {28'd0, obs}, 32'h4);
    end
    do_move(4'b0000, 0, 1'b0, obs);
    chk("escape_resume_up", {28'd0, obs}, 32'h1);
`else
    do_move(4'b0000, 0, 1'b0, obs);
    chk("noescape_left", {28'd0, obs}, 32'h2);
`endif

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      logic [3:0] s;
      s[0] = ($urandom_range(0, 2) == 0);
      s[1] = ($urandom_range(0, 2) == 0);
      s[2] = ($urandom_range(0, 2) == 0);
      s[3] = ($urandom_range(0, 3) == 0);
      do_move(s, $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0), obs);
`ifndef SCOOT_ESCAPE_EN
      chk("never_down", {28'd0, obs & 4'b0100}, 32'd0);
`endif
    end

    // Reset in the middle of an ISSUE cycle after a collecting move
    do_move(4'b0001, 0, 1'b0, obs);
    {sense_right, sense_down, sense_left, sense_up} = 4'b0000;
    @(posedge clk); #2;
    chk("pre_abort_valid", {31'd0, move_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, move_valid}, 32'd0);
    chk("abort_move", {28'd0, move}, 32'd0);
    chk("abort_collected", {{(32-CNT_W){1'b0}}, collected}, 32'd0);
    model_reset();
    release_reset();

    // Saturating score
    for (int i = 0; i < 5; i++) begin
      do_move(4'b0001, 0, 1'b0, obs);
      chk("sat_collected", {{(32-CNT_W){1'b0}}, collected}, {{(32-CNT_W){1'b0}}, sat_tab[i]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
